ysyx_23060191_lsu_mem: RTL and testbench

//  Multi-cycle load/store unit; replaces the single-cycle DPI-backed LSU. Sits between EXU (request side)
//  and the data-memory bus (req/rsp handshake). Handles byte/half/word/dword sizes with lane shifting,

---
 rtl/ysyx_23060191_lsu_mem.sv | 220 ++++++++++++++++++++++
 tb/tb_ysyx_23060191_lsu_mem.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060191_lsu_mem.sv
// Multi-cycle load/store unit between the EXU request port and the data-memory bus.
// One access in flight. Byte/half/word/dword accesses are lane-shifted onto an aligned
// bus beat; loads are extracted and sign/zero extended; misaligned accesses and bus
// errors are reported through resp_err with resp_rdata forced to zero.
//
// Handshake rule for every port pair (req_*, resp_*, mem_req_*): a transfer happens on
// a rising clk edge where valid and ready are both high; once valid is raised, it and
// its payload hold steady until that edge. mem_rsp_valid is a one-cycle pulse with no
// ready, honoured only while waiting for it.
module ysyx_23060191_lsu_mem #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_rdata,
    input  logic                mem_rsp_err,
    output logic [1:0]          dbg_state
);

    localparam int NB    = XLEN / 8;
    localparam int OFS_W = $clog2(NB);

    // Left/right shift amounts used to sign- or zero-extend a narrow lane.
    localparam logic [6:0] EXT_SH_B = 7'(XLEN - 8);
    localparam logic [6:0] EXT_SH_H = 7'(XLEN - 16);
    localparam logic [6:0] EXT_SH_W = 7'(XLEN - 32);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic                unsigned_q, unsigned_d;
    logic [1:0]          size_q, size_d;
    logic [OFS_W-1:0]    ofs_q, ofs_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [NB-1:0]       wstrb_q, wstrb_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic                err_q, err_d;

    // Request-side decode signals
    logic [OFS_W-1:0]    req_ofs;
    logic [OFS_W+2:0]    req_shamt;
    logic [7:0]          size_mask;
    logic                req_misaligned;
    logic [NB-1:0]       req_strb;
    logic [ADDR_W-1:0]   req_addr_aligned;

    // Response-side extraction signals
    logic [OFS_W+2:0]    rsp_shamt;
    logic [XLEN-1:0]     rsp_lane;
    logic [6:0]          ext_sh;
    logic [XLEN-1:0]     ext_tmp;
    logic [XLEN-1:0]     ext_zext;
    logic [XLEN-1:0]     ext_sext;
    logic [XLEN-1:0]     load_data;

    // Decode the incoming request: byte offset, strobe mask and alignment check.
    always_comb begin
        req_ofs          = req_addr[OFS_W-1:0];
        req_shamt        = {req_ofs, 3'b000};
        req_addr_aligned = {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
        size_mask        = 8'h01;
        req_misaligned   = 1'b0;
        case (req_op[1:0])
            2'd0: begin
                size_mask      = 8'h01;
                req_misaligned = 1'b0;
            end
            2'd1: begin
                size_mask      = 8'h03;
                req_misaligned = req_addr[0];
            end
            2'd2: begin
                size_mask      = 8'h0F;
                req_misaligned = |req_addr[1:0];
            end
            default: begin
                // Dword accesses only exist on a 64-bit datapath.
                size_mask      = 8'hFF;
                req_misaligned = (XLEN == 32) || (|req_addr[2:0]);
            end
        endcase
        req_strb = size_mask[NB-1:0] << req_ofs;
    end

    // Pull the addressed lane out of the bus beat and extend it to XLEN.
    always_comb begin
        rsp_shamt = {ofs_q, 3'b000};
        rsp_lane  = mem_rsp_rdata >> rsp_shamt;
        case (size_q)
            2'd0:    ext_sh = EXT_SH_B;
            2'd1:    ext_sh = EXT_SH_H;
            2'd2:    ext_sh = EXT_SH_W;
            default: ext_sh = 7'd0;
        endcase
        ext_tmp  = rsp_lane << ext_sh;
        ext_zext = ext_tmp >> ext_sh;
        // Kept as its own expression so the shift stays arithmetic.
        ext_sext = $signed(ext_tmp) >>> ext_sh;
        load_data = unsigned_q ? ext_zext : ext_sext;
    end

    // Next-state logic and register updates for the access FSM.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        unsigned_d = unsigned_q;
        size_d     = size_q;
        ofs_d      = ofs_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d       = req_op[3];
                    unsigned_d = req_op[2];
                    size_d     = req_op[1:0];
                    ofs_d      = req_ofs;
                    addr_d     = req_addr_aligned;
                    wdata_d    = req_wdata << req_shamt;
                    wstrb_d    = req_op[3] ? req_strb : '0;
                    rdata_d    = '0;
                    if (req_misaligned) begin
                        // Answer directly without touching the bus.
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    err_d   = mem_rsp_err;
                    rdata_d = (mem_rsp_err || we_q) ? '0 : load_data;
                    state_d = S_RESP;
                end
            end
            default: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; reset drops any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'd0;
            ofs_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            unsigned_q <= unsigned_d;
            size_q     <= size_d;
            ofs_q      <= ofs_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // All outputs come straight from registers or the decoded state.
    always_comb begin
        req_ready     = (state_q == S_IDLE);
        mem_req_valid = (state_q == S_REQ);
        resp_valid    = (state_q == S_RESP);
        mem_we        = we_q;
        mem_addr      = addr_q;
        mem_wdata     = wdata_q;
        mem_wstrb     = wstrb_q;
        resp_rdata    = rdata_q;
        resp_err      = err_q;
        dbg_state     = state_q;
    end

endmodule

// File: tb/tb_ysyx_23060191_lsu_mem.sv
// Bench for ysyx_23060191_lsu_mem: a 32-bit instance driven through a scoreboard with a
// bus responder and a response monitor, plus a 64-bit instance exercised with directed
// dword/word/byte accesses.
module tb_ysyx_23060191_lsu_mem;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_main;
    logic rst_bus;
    logic rst;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    assign rst = rst_main | rst_bus;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- 32-bit DUT ----------------
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid, mem_rsp_err;
    logic [31:0] mem_rsp_rdata;
    logic [1:0]  dbg_state;

    ysyx_23060191_lsu_mem #(.XLEN(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
        .dbg_state(dbg_state)
    );

    // ---------------- 64-bit DUT ----------------
    logic        h_req_valid, h_req_ready;
    logic [3:0]  h_req_op;
    logic [31:0] h_req_addr;
    logic [63:0] h_req_wdata;
    logic        h_resp_valid, h_resp_ready, h_resp_err;
    logic [63:0] h_resp_rdata;
    logic        h_mem_req_valid, h_mem_req_ready, h_mem_we;
    logic [31:0] h_mem_addr;
    logic [63:0] h_mem_wdata;
    logic [7:0]  h_mem_wstrb;
    logic        h_mem_rsp_valid, h_mem_rsp_err;
    logic [63:0] h_mem_rsp_rdata;
    logic [1:0]  h_dbg_state;

    ysyx_23060191_lsu_mem #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(h_req_valid), .req_ready(h_req_ready), .req_op(h_req_op),
        .req_addr(h_req_addr), .req_wdata(h_req_wdata),
        .resp_valid(h_resp_valid), .resp_ready(h_resp_ready),
        .resp_rdata(h_resp_rdata), .resp_err(h_resp_err),
        .mem_req_valid(h_mem_req_valid), .mem_req_ready(h_mem_req_ready),
        .mem_we(h_mem_we), .mem_addr(h_mem_addr), .mem_wdata(h_mem_wdata), .mem_wstrb(h_mem_wstrb),
        .mem_rsp_valid(h_mem_rsp_valid), .mem_rsp_rdata(h_mem_rsp_rdata), .mem_rsp_err(h_mem_rsp_err),
        .dbg_state(h_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
        int          dreq;
        int          drsp;
        logic        abort;
    } bus_t;

    logic [32:0] exp_q[$];   // {err, rdata}
    int          lat_q[$];   // expected accept->resp_valid cycles
    int          dly_q[$];   // cycles to hold resp_ready low
    bus_t        bus_q[$];
    int          accept_cyc;
    logic        bus_busy;
    int          n_vec;
    int          n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        @(negedge clk);
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_accept_timeout", {63'd0, req_ready}, 64'd1);
        accept_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Push the expected bus beat (if any) and response, then present the request.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic has_bus, input logic abort,
                         input logic [31:0] b_addr, input logic b_we, input logic [31:0] b_wdata,
                         input logic [3:0] b_wstrb, input logic [31:0] b_rdata, input logic b_err,
                         input int dreq, input int drsp, input int dresp,
                         input logic [31:0] e_rdata, input logic e_err, input int e_lat);
        bus_t b;
        if (has_bus) begin
            b.addr  = b_addr;  b.we   = b_we;   b.wdata = b_wdata; b.wstrb = b_wstrb;
            b.rdata = b_rdata; b.err  = b_err;  b.dreq  = dreq;    b.drsp  = drsp;
            b.abort = abort;
            bus_q.push_back(b);
        end
        if (!abort) begin
            exp_q.push_back({e_err, e_rdata});
            lat_q.push_back(e_lat);
            dly_q.push_back(dresp);
        end
        drive(op, addr, wdata);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && bus_q.size() == 0 && !bus_busy && req_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 64'(exp_q.size() + bus_q.size()), 64'd0);
    endtask

    // ---------------- bus responder (checks the issued beat) ----------------
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        mem_rsp_err   = 1'b0;
        rst_bus       = 1'b0;
        bus_busy      = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && mem_req_valid) begin
                if (bus_q.size() == 0) begin
                    check("mem_req_valid_unexpected", {63'd0, mem_req_valid}, 64'd0);
                end else begin
                    bus_t b;
                    b = bus_q.pop_front();
                    bus_busy = 1'b1;
                    check("mem_addr", 64'(mem_addr), 64'(b.addr));
                    check("mem_we", {63'd0, mem_we}, {63'd0, b.we});
                    check("mem_wdata", 64'(mem_wdata), 64'(b.wdata));
                    check("mem_wstrb", 64'(mem_wstrb), 64'(b.wstrb));
                    for (int i = 0; i < b.dreq; i++) begin
                        @(negedge clk);
                        check("mem_req_valid_hold", {63'd0, mem_req_valid}, 64'd1);
                        check("mem_addr_hold", 64'(mem_addr), 64'(b.addr));
                        check("mem_wdata_hold", 64'(mem_wdata), 64'(b.wdata));
                        check("mem_wstrb_hold", 64'(mem_wstrb), 64'(b.wstrb));
                    end
                    mem_req_ready = 1'b1;
                    @(negedge clk);
                    mem_req_ready = 1'b0;
                    check("mem_req_valid_drop", {63'd0, mem_req_valid}, 64'd0);
                    if (b.abort) begin
                        rst_bus = 1'b1;
                        @(negedge clk);
                        rst_bus = 1'b0;
                        check("abort_state_idle", 64'(dbg_state), 64'd0);
                        check("abort_req_ready", {63'd0, req_ready}, 64'd1);
                    end
                    for (int i = 0; i < b.drsp; i++) @(negedge clk);
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = b.rdata;
                    mem_rsp_err   = b.err;
                    @(negedge clk);
                    mem_rsp_valid = 1'b0;
                    mem_rsp_rdata = '0;
                    mem_rsp_err   = 1'b0;
                    if (b.abort) begin
                        check("abort_no_resp_valid", {63'd0, resp_valid}, 64'd0);
                        check("abort_idle_after_stray", 64'(dbg_state), 64'd0);
                    end
                    bus_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin
        resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("resp_valid_unexpected", {63'd0, resp_valid}, 64'd0);
                    resp_ready = 1'b1;
                    @(negedge clk);
                    resp_ready = 1'b0;
                end else begin
                    logic [32:0] e;
                    int          lat;
                    int          d;
                    e   = exp_q.pop_front();
                    lat = lat_q.pop_front();
                    d   = dly_q.pop_front();
                    check("resp_rdata", 64'(resp_rdata), 64'(e[31:0]));
                    check("resp_err", {63'd0, resp_err}, {63'd0, e[32]});
                    check("resp_latency", 64'(cyc - accept_cyc), 64'(lat));
                    for (int i = 0; i < d; i++) begin
                        @(negedge clk);
                        check("resp_valid_hold", {63'd0, resp_valid}, 64'd1);
                        check("resp_rdata_hold", 64'(resp_rdata), 64'(e[31:0]));
                        check("resp_err_hold", {63'd0, resp_err}, {63'd0, e[32]});
                    end
                    resp_ready = 1'b1;
                    @(negedge clk);
                    resp_ready = 1'b0;
                    check("resp_valid_drop", {63'd0, resp_valid}, 64'd0);
                end
            end
        end
    end

    // ---------------- 64-bit directed access ----------------
    task automatic t64(input logic [3:0] op, input logic [31:0] addr, input logic [63:0] wdata,
                       input logic misal, input logic [63:0] b_rdata,
                       input logic [31:0] e_addr, input logic e_we, input logic [63:0] e_wdata,
                       input logic [7:0] e_wstrb, input logic [63:0] e_rdata, input logic e_err);
        @(negedge clk);
        h_req_op    = op;
        h_req_addr  = addr;
        h_req_wdata = wdata;
        h_req_valid = 1'b1;
        check("x64_req_ready", {63'd0, h_req_ready}, 64'd1);
        @(negedge clk);
        h_req_valid = 1'b0;
        if (misal) begin
            check("x64_no_mem_req", {63'd0, h_mem_req_valid}, 64'd0);
        end else begin
            check("x64_mem_req_valid", {63'd0, h_mem_req_valid}, 64'd1);
            check("x64_mem_addr", 64'(h_mem_addr), 64'(e_addr));
            check("x64_mem_we", {63'd0, h_mem_we}, {63'd0, e_we});
            check("x64_mem_wdata", h_mem_wdata, e_wdata);
            check("x64_mem_wstrb", 64'(h_mem_wstrb), 64'(e_wstrb));
            h_mem_req_ready = 1'b1;
            @(negedge clk);
            h_mem_req_ready = 1'b0;
            h_mem_rsp_valid = 1'b1;
            h_mem_rsp_rdata = b_rdata;
            @(negedge clk);
            h_mem_rsp_valid = 1'b0;
            h_mem_rsp_rdata = '0;
        end
        check("x64_resp_valid", {63'd0, h_resp_valid}, 64'd1);
        check("x64_resp_rdata", h_resp_rdata, e_rdata);
        check("x64_resp_err", {63'd0, h_resp_err}, {63'd0, e_err});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        n_fail++;
        $display("FAIL watchdog: run did not complete within time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        n_vec = 0;
        n_fail = 0;
        accept_cyc = 0;
        rst_main = 1'b1;
        req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        h_req_valid = 1'b0; h_req_op = '0; h_req_addr = '0; h_req_wdata = '0;
        h_resp_ready = 1'b1; h_mem_req_ready = 1'b0; h_mem_rsp_valid = 1'b0;
        h_mem_rsp_rdata = '0; h_mem_rsp_err = 1'b0;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_err", {63'd0, resp_err}, 64'd0);
        check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        check("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check("rst_mem_we", {63'd0, mem_we}, 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
        check("rst64_req_ready", {63'd0, h_req_ready}, 64'd1);
        check("rst64_mem_wstrb", 64'(h_mem_wstrb), 64'd0);
        rst_main = 1'b0;

        //    op     addr          wdata        bus  abrt b_addr        we   b_wdata       strb  b_rdata       berr dreq drsp dresp e_rdata      e_err lat
        issue(4'h2, 32'h8000_0004, 32'h0,        1, 0, 32'h8000_0004, 0, 32'h0,        4'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 3);  // LW
        issue(4'h0, 32'h8000_0003, 32'h0,        1, 0, 32'h8000_0000, 0, 32'h0,        4'h0, 32'h8012_3456, 0, 0, 0, 0, 32'hFFFF_FF80, 0, 3);  // LB
        issue(4'h4, 32'h8000_0003, 32'h0,        1, 0, 32'h8000_0000, 0, 32'h0,        4'h0, 32'h8012_3456, 0, 0, 0, 0, 32'h0000_0080, 0, 3);  // LBU
        issue(4'h5, 32'h8000_0002, 32'h0,        1, 0, 32'h8000_0000, 0, 32'h0,        4'h0, 32'h8012_3456, 0, 0, 0, 0, 32'h0000_8012, 0, 3);  // LHU
        issue(4'h1, 32'h8000_0002, 32'h0,        1, 0, 32'h8000_0000, 0, 32'h0,        4'h0, 32'h8012_3456, 0, 0, 0, 0, 32'hFFFF_8012, 0, 3);  // LH
        issue(4'h9, 32'h8000_0002, 32'h1234_ABCD, 1, 0, 32'h8000_0000, 1, 32'hABCD_0000, 4'hC, 32'h0,        0, 0, 0, 0, 32'h0,        0, 3);  // SH
        issue(4'h8, 32'h8000_0001, 32'h0000_00EE, 1, 0, 32'h8000_0000, 1, 32'h0000_EE00, 4'h2, 32'h0,        0, 0, 0, 0, 32'h0,        0, 3);  // SB
        issue(4'hA, 32'h8000_0008, 32'hCAFE_F00D, 1, 0, 32'h8000_0008, 1, 32'hCAFE_F00D, 4'hF, 32'h0,        0, 0, 0, 0, 32'h0,        0, 3);  // SW
        issue(4'h2, 32'h8000_0002, 32'h0,        0, 0, 32'h0,         0, 32'h0,        4'h0, 32'h0,        0, 0, 0, 0, 32'h0,        1, 1);  // LW misaligned
        issue(4'h3, 32'h8000_0000, 32'h0,        0, 0, 32'h0,         0, 32'h0,        4'h0, 32'h0,        0, 0, 0, 0, 32'h0,        1, 1);  // LD on XLEN=32
        issue(4'h1, 32'h8000_0001, 32'h0,        0, 0, 32'h0,         0, 32'h0,        4'h0, 32'h0,        0, 0, 0, 0, 32'h0,        1, 1);  // LH misaligned
        issue(4'h2, 32'h8000_0010, 32'h0,        1, 0, 32'h8000_0010, 0, 32'h0,        4'h0, 32'h1234_5678, 0, 5, 0, 4, 32'h1234_5678, 0, 8);  // LW, bus/EXU stalls
        issue(4'h2, 32'h8000_0014, 32'h0,        1, 0, 32'h8000_0014, 0, 32'h0,        4'h0, 32'hFFFF_FFFF, 1, 0, 2, 0, 32'h0,        1, 5);  // LW bus error
        issue(4'hA, 32'h8000_000C, 32'h55AA_55AA, 1, 0, 32'h8000_000C, 1, 32'h55AA_55AA, 4'hF, 32'h0,        1, 0, 0, 0, 32'h0,        1, 3);  // SW bus error
        wait_idle();

        // reset while waiting for the bus, then a stray response pulse
        issue(4'h2, 32'h8000_0020, 32'h0,        1, 1, 32'h8000_0020, 0, 32'h0,        4'h0, 32'h1111_1111, 0, 0, 0, 0, 32'h0,        0, 0);
        wait_idle();

        // normal operation after the abort; op[2] on a store is ignored
        issue(4'h4, 32'h8000_0000, 32'h0,        1, 0, 32'h8000_0000, 0, 32'h0,        4'h0, 32'h0000_00FF, 0, 0, 0, 0, 32'h0000_00FF, 0, 3);  // LBU
        issue(4'hC, 32'h8000_0003, 32'h0000_005A, 1, 0, 32'h8000_0000, 1, 32'h5A00_0000, 4'h8, 32'h0,        0, 0, 0, 0, 32'h0,        0, 3);  // SB (+unsigned bit)
        wait_idle();

        // 64-bit instance
        //  op    addr          wdata                   mis b_rdata                 e_addr        we  e_wdata                 strb   e_rdata                 err
        t64(4'hB, 32'h8000_0008, 64'h1122_3344_5566_7788, 0, 64'h0,                  32'h8000_0008, 1, 64'h1122_3344_5566_7788, 8'hFF, 64'h0,                  0);  // SD
        t64(4'h2, 32'h8000_0004, 64'h0,                  0, 64'hDEAD_BEEF_0000_0000, 32'h8000_0000, 0, 64'h0,                  8'h00, 64'hFFFF_FFFF_DEAD_BEEF, 0);  // LW
        t64(4'h6, 32'h8000_0004, 64'h0,                  0, 64'hDEAD_BEEF_0000_0000, 32'h8000_0000, 0, 64'h0,                  8'h00, 64'h0000_0000_DEAD_BEEF, 0);  // LWU
        t64(4'h3, 32'h8000_0010, 64'h0,                  0, 64'h0123_4567_89AB_CDEF, 32'h8000_0010, 0, 64'h0,                  8'h00, 64'h0123_4567_89AB_CDEF, 0);  // LD
        t64(4'h8, 32'h8000_0005, 64'h0000_0000_0000_00AB, 0, 64'h0,                  32'h8000_0000, 1, 64'h0000_AB00_0000_0000, 8'h20, 64'h0,                  0);  // SB
        t64(4'h3, 32'h8000_0004, 64'h0,                  1, 64'h0,                  32'h0,         0, 64'h0,                  8'h00, 64'h0,                  1);  // LD misaligned

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
